control_suma_serial: RTL



---
 rtl/control_suma_serial.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/control_suma_serial.sv
// ---------------------------------------------------------------------------
// control_suma_serial
//
// Nibble-serial sequencer that computes a (4*NIBBLES)-bit sum on a single
// shared 4-bit ripple-carry adder. One nibble is processed per clock, least
// significant first, with the carry chained through a register.
//
// Handshake is start/busy/done:
//   - start is sampled only in IDLE or DONE; the accepting edge captures
//     a, b, cin (and op when subtraction is built in).
//   - busy is high for NIBBLES cycles while nibbles are processed.
//   - done pulses for one cycle when result/cout/ovf are complete.
//
// Optional feature macro: SUB_EN
//   defined   : op port present; op=1 computes a - b (b inverted, carry-in
//               forced to 1, cin ignored); cout=1 then means "no borrow".
//   undefined : no op port, addition only.
//
// Parameters:
//   NIBBLES  number of 4-bit slices (legal range 2..16), operand width
//            is 4*NIBBLES.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request (pulse or level)
//   a       in   operand A, captured on the accepting edge
//   b       in   operand B, captured on the accepting edge
//   cin     in   carry-in, captured on the accepting edge
//   op      in   0 = add, 1 = subtract (SUB_EN builds only)
//   busy    out  high while nibbles are being processed
//   done    out  one-cycle completion pulse
//   result  out  sum modulo 2^(4*NIBBLES); partial during busy, stable
//                from done until the next accept
//   cout    out  carry out of the most significant nibble
//   ovf     out  two's-complement overflow of the full-width result
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// sumador_rc4
//
// Shared 4-bit ripple-carry adder: w = x + y + cin, w[4] is the carry out.
//
// Ports:
//   x    in   4-bit addend
//   y    in   4-bit addend
//   cin  in   carry-in
//   w    out  5-bit sum (w[4] = carry out)
// ---------------------------------------------------------------------------
module sumador_rc4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [4:0] w
);

    // c[i] is the carry into bit i; c[4] is the carry out of the slice.
    logic [4:0] c;

    always_comb begin
        c    = '0;
        w    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            w[i]     = x[i] ^ y[i] ^ c[i];
            c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        w[4] = c[4];
    end

endmodule

module control_suma_serial #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
`ifdef SUB_EN
    input  logic                   op,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   ovf
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic [W-1:0]     a_q,      a_d;
    // Holds the effective B operand (already inverted for subtraction).
    logic [W-1:0]     b_q,      b_d;
    logic [W-1:0]     result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    // ------------------------------------------------------------------
    // Adder slice selection
    // ------------------------------------------------------------------
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [4:0] w_sum;
    logic       accept;
    logic       last_nib;
    logic [W-1:0] b_eff_in;
    logic         carry_init;

    // Decode-style nibble mux: keeps every operand bit visibly used and
    // maps to a plain one-hot select in synthesis.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*4 +: 4];
                nib_b = b_q[i*4 +: 4];
            end
        end
    end

    sumador_rc4 u_adder (
        .x   (nib_a),
        .y   (nib_b),
        .cin (carry_q),
        .w   (w_sum)
    );

    // ------------------------------------------------------------------
    // Operand conditioning on accept
    // ------------------------------------------------------------------
`ifdef SUB_EN
    always_comb begin
        b_eff_in   = op ? ~b : b;
        carry_init = op ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_eff_in   = b;
        carry_init = cin;
    end
`endif

    assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d  = S_RUN;
                    idx_d    = '0;
                    carry_d  = carry_init;
                    a_d      = a;
                    b_d      = b_eff_in;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        result_d[i*4 +: 4] = w_sum[3:0];
                    end
                end
                carry_d = w_sum[4];
                if (last_nib) begin
                    // Overflow: operands share a sign that the top bit of
                    // the sum does not.
                    idx_d   = '0;
                    cout_d  = w_sum[4];
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (w_sum[3] != a_q[W-1]);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule
